// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control FSM for a MIPS-subset CPU: sequences fetch/decode/
// execute/memory/writeback and drives ALU op, operand selects and datapath enables.
module multicycle_ctrl #(
  parameter int OP_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [OP_W-1:0] opcode,
  input  logic [OP_W-1:0] funct,
  input  logic            zero,
  input  logic            overflow,
  output logic [3:0]      aluOp,
  output logic            aluSrcA,
  output logic [1:0]      aluSrcB,
  output logic            pcEn,
  output logic [1:0]      pcSrc,
  output logic            iorD,
  output logic            memWrite,
  output logic            irWrite,
  output logic            regDst,
  output logic            memToReg,
  output logic            regWrite,
  output logic            fault
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  RTEXEC = 4'd6,  RTWB   = 4'd7,
    ADDIEX = 4'd8,  ORIEX  = 4'd9,  IMMWB  = 4'd10, BRANCH = 4'd11,
    JUMP   = 4'd12, FAULT  = 4'd13
  } state_e;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_en;
    logic [1:0] pc_src;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       fault;
    logic       branch;
  } ctrl_t;

  localparam logic [OP_W-1:0] OPC_RT   = 6'b000000;
  localparam logic [OP_W-1:0] OPC_LW   = 6'b100011;
  localparam logic [OP_W-1:0] OPC_SW   = 6'b101011;
  localparam logic [OP_W-1:0] OPC_BEQ  = 6'b000100;
  localparam logic [OP_W-1:0] OPC_ADDI = 6'b001000;
  localparam logic [OP_W-1:0] OPC_ORI  = 6'b001101;
  localparam logic [OP_W-1:0] OPC_J    = 6'b000010;

  // Returns {legal, alu_op} for an R-type funct field.
  function automatic logic [4:0] funct_decode(input logic [OP_W-1:0] f);
    logic [4:0] d;
    case (f)
      6'b100000: d = {1'b1, 4'b0010};
      6'b100010: d = {1'b1, 4'b0110};
      6'b100100: d = {1'b1, 4'b0000};
      6'b100101: d = {1'b1, 4'b0001};
      6'b100111: d = {1'b1, 4'b1100};
      6'b101010: d = {1'b1, 4'b0111};
      default:   d = {1'b0, 4'b0010};
    endcase
    return d;
  endfunction

  // Moore output word for a state; rt_op supplies the decoded funct for RTEXEC.
  function automatic ctrl_t ctrl_of(input state_e st, input logic [3:0] rt_op);
    ctrl_t c;
    c = '0;
    c.alu_op = 4'b0010;
    case (st)
      FETCH:  begin c.ir_write = 1'b1; c.alu_src_b = 2'b01; c.pc_en = 1'b1; end
      DECODE: begin c.alu_src_b = 2'b11; end
      MEMADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      MEMRD:  begin c.iord = 1'b1; end
      MEMWB:  begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      MEMWR:  begin c.iord = 1'b1; c.mem_write = 1'b1; end
      RTEXEC: begin c.alu_src_a = 1'b1; c.alu_op = rt_op; end
      RTWB:   begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      ORIEX:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 4'b0001; end
      IMMWB:  begin c.reg_write = 1'b1; end
      BRANCH: begin c.alu_src_a = 1'b1; c.alu_op = 4'b0110; c.pc_src = 2'b01; c.branch = 1'b1; end
      JUMP:   begin c.pc_src = 2'b10; c.pc_en = 1'b1; end
      FAULT:  begin c.fault = 1'b1; end
      default: begin c.fault = 1'b1; end
    endcase
    return c;
  endfunction

  state_e     state_r;
  state_e     state_nxt_s;
  ctrl_t      ctrl_r;
  ctrl_t      ctrl_nxt_s;
  logic [4:0] funct_dec_s;
  logic       rt_arith_r;

  assign funct_dec_s = funct_decode(funct);

  // State, output and add/sub-flag registers; outputs are registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= FETCH;
      ctrl_r     <= ctrl_of(FETCH, 4'b0010);
      rt_arith_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ctrl_r  <= ctrl_nxt_s;
      if (state_r == DECODE) begin
        rt_arith_r <= (funct == 6'b100000) || (funct == 6'b100010);
      end else begin
        rt_arith_r <= rt_arith_r;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      FETCH:  state_nxt_s = DECODE;
      DECODE: begin
        case (opcode)
          OPC_LW, OPC_SW: state_nxt_s = MEMADR;
          OPC_RT: begin
            if (funct_dec_s[4]) begin
              state_nxt_s = RTEXEC;
            end else begin
              state_nxt_s = FAULT;
            end
          end
          OPC_BEQ:  state_nxt_s = BRANCH;
          OPC_ADDI: state_nxt_s = ADDIEX;
          OPC_ORI:  state_nxt_s = ORIEX;
          OPC_J:    state_nxt_s = JUMP;
          default:  state_nxt_s = FAULT;
        endcase
      end
      MEMADR: begin
        if (opcode == OPC_LW) begin
          state_nxt_s = MEMRD;
        end else begin
          state_nxt_s = MEMWR;
        end
      end
      MEMRD:  state_nxt_s = MEMWB;
      MEMWB:  state_nxt_s = FETCH;
      MEMWR:  state_nxt_s = FETCH;
      // Overflow only traps for add/sub; for slt it is the carry-out.
      RTEXEC: begin
        if (overflow && rt_arith_r) begin
          state_nxt_s = FAULT;
        end else begin
          state_nxt_s = RTWB;
        end
      end
      RTWB:   state_nxt_s = FETCH;
      ADDIEX: begin
        if (overflow) begin
          state_nxt_s = FAULT;
        end else begin
          state_nxt_s = IMMWB;
        end
      end
      ORIEX:  state_nxt_s = IMMWB;
      IMMWB:  state_nxt_s = FETCH;
      BRANCH: state_nxt_s = FETCH;
      JUMP:   state_nxt_s = FETCH;
      FAULT:  state_nxt_s = FAULT;
      default: state_nxt_s = FAULT;
    endcase
  end

  // Output decode of the upcoming state.
  always_comb begin
    ctrl_nxt_s = ctrl_of(state_nxt_s, funct_dec_s[3:0]);
  end

  assign aluOp    = ctrl_r.alu_op;
  assign aluSrcA  = ctrl_r.alu_src_a;
  assign aluSrcB  = ctrl_r.alu_src_b;
  assign pcEn     = ctrl_r.pc_en | (ctrl_r.branch & zero);
  assign pcSrc    = ctrl_r.pc_src;
  assign iorD     = ctrl_r.iord;
  assign memWrite = ctrl_r.mem_write;
  assign irWrite  = ctrl_r.ir_write;
  assign regDst   = ctrl_r.reg_dst;
  assign memToReg = ctrl_r.mem_to_reg;
  assign regWrite = ctrl_r.reg_write;
  assign fault    = ctrl_r.fault;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed table, hand-written corner
// sequences and randomized instructions against an instruction-level model.
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, overflow;
  logic [3:0] aluOp;
  logic       aluSrcA, pcEn, iorD, memWrite, irWrite, regDst, memToReg, regWrite, fault;
  logic [1:0] aluSrcB, pcSrc;

  multicycle_ctrl #(.OP_W(6)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .overflow(overflow), .aluOp(aluOp), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .pcEn(pcEn), .pcSrc(pcSrc), .iorD(iorD), .memWrite(memWrite), .irWrite(irWrite),
    .regDst(regDst), .memToReg(memToReg), .regWrite(regWrite), .fault(fault)
  );

  // {aluOp, aluSrcA, aluSrcB, pcEn, pcSrc, iorD, memWrite, irWrite, regDst, memToReg, regWrite, fault}
  logic [16:0] obs;
  assign obs = {aluOp, aluSrcA, aluSrcB, pcEn, pcSrc, iorD, memWrite, irWrite,
                regDst, memToReg, regWrite, fault};

  localparam logic [16:0] V_F     = {4'b0010, 1'b0, 2'b01, 1'b1, 2'b00, 7'b0010000};
  localparam logic [16:0] V_D     = {4'b0010, 1'b0, 2'b11, 1'b0, 2'b00, 7'b0000000};
  localparam logic [16:0] V_MA    = {4'b0010, 1'b1, 2'b10, 1'b0, 2'b00, 7'b0000000};
  localparam logic [16:0] V_MR    = {4'b0010, 1'b0, 2'b00, 1'b0, 2'b00, 7'b1000000};
  localparam logic [16:0] V_MWB   = {4'b0010, 1'b0, 2'b00, 1'b0, 2'b00, 7'b0000110};
  localparam logic [16:0] V_MW    = {4'b0010, 1'b0, 2'b00, 1'b0, 2'b00, 7'b1100000};
  localparam logic [16:0] V_RTWB  = {4'b0010, 1'b0, 2'b00, 1'b0, 2'b00, 7'b0001010};
  localparam logic [16:0] V_IMMWB = {4'b0010, 1'b0, 2'b00, 1'b0, 2'b00, 7'b0000010};
  localparam logic [16:0] V_ADDI  = {4'b0010, 1'b1, 2'b10, 1'b0, 2'b00, 7'b0000000};
  localparam logic [16:0] V_ORI   = {4'b0001, 1'b1, 2'b10, 1'b0, 2'b00, 7'b0000000};
  localparam logic [16:0] V_J     = {4'b0010, 1'b0, 2'b00, 1'b1, 2'b10, 7'b0000000};
  localparam logic [16:0] V_FLT   = {4'b0010, 1'b0, 2'b00, 1'b0, 2'b00, 7'b0000001};

  int n_chk  = 0;
  int n_fail = 0;
  logic [16:0] exp_q[$];

  task automatic check(input string nm, input logic [16:0] got, input logic [16:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Returns {legal, aluOp} for an R-type funct.
  function automatic logic [4:0] fmap(input logic [5:0] f);
    case (f)
      6'b100000: return {1'b1, 4'b0010};
      6'b100010: return {1'b1, 4'b0110};
      6'b100100: return {1'b1, 4'b0000};
      6'b100101: return {1'b1, 4'b0001};
      6'b100111: return {1'b1, 4'b1100};
      6'b101010: return {1'b1, 4'b0111};
      default:   return 5'b00000;
    endcase
  endfunction

  // Instruction-level model: the full per-cycle output trace of one instruction.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic ov);
    logic [4:0] fm;
    fm = fmap(fn);
    exp_q.delete();
    exp_q.push_back(V_F);
    exp_q.push_back(V_D);
    case (op)
      6'b100011: begin exp_q.push_back(V_MA); exp_q.push_back(V_MR); exp_q.push_back(V_MWB); end
      6'b101011: begin exp_q.push_back(V_MA); exp_q.push_back(V_MW); end
      6'b000000: begin
        if (!fm[4]) exp_q.push_back(V_FLT);
        else begin
          exp_q.push_back({fm[3:0], 1'b1, 2'b00, 1'b0, 2'b00, 7'b0000000});
          if (ov && (fn == 6'b100000 || fn == 6'b100010)) exp_q.push_back(V_FLT);
          else exp_q.push_back(V_RTWB);
        end
      end
      6'b000100: exp_q.push_back({4'b0110, 1'b1, 2'b00, z, 2'b01, 7'b0000000});
      6'b001000: begin exp_q.push_back(V_ADDI); exp_q.push_back(ov ? V_FLT : V_IMMWB); end
      6'b001101: begin exp_q.push_back(V_ORI); exp_q.push_back(V_IMMWB); end
      6'b000010: exp_q.push_back(V_J);
      default:   exp_q.push_back(V_FLT);
    endcase
  endtask

  // Hold in FAULT for n cycles, then reset back to FETCH.
  task automatic fault_then_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
      check("fault_hold", obs, V_FLT);
    end
    reset = 1'b1;
    @(negedge clk); #1;
    check("fault_reset_fetch", obs, V_F);
    reset = 1'b0;
  endtask

  // Called at a FETCH cycle (negedge+1): compare every cycle against the model.
  task automatic run_model(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic ov);
    opcode = op; funct = fn; zero = z; overflow = ov;
    build(op, fn, z, ov);
    #1;
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("model op=%b fn=%b cyc%0d", op, fn, i), obs, exp_q[i]);
      check("inv_mem_reg", {16'h0, memWrite & regWrite}, 17'h0);
      if (i < exp_q.size() - 1) begin
        @(negedge clk); #1;
      end
    end
    if (exp_q[exp_q.size()-1] == V_FLT) fault_then_reset(2);
    else begin
      @(negedge clk); #1;
    end
  endtask

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic       ov;
    int         lat;
    logic [3:0] alu;
    int         regw;
    int         memw;
    int         pce;
    logic       flt;
  } vec_t;

  vec_t tbl[16];
  logic [5:0] ops[8];

  initial begin
    tbl[0]  = '{6'b100011, 6'b000000, 1'b0, 1'b0, 5, 4'b0010, 1, 0, 1, 1'b0}; // lw
    tbl[1]  = '{6'b101011, 6'b000000, 1'b0, 1'b0, 4, 4'b0010, 0, 1, 1, 1'b0}; // sw
    tbl[2]  = '{6'b000000, 6'b100111, 1'b0, 1'b0, 4, 4'b1100, 1, 0, 1, 1'b0}; // nor
    tbl[3]  = '{6'b000000, 6'b101010, 1'b0, 1'b1, 4, 4'b0111, 1, 0, 1, 1'b0}; // slt, carry
    tbl[4]  = '{6'b000000, 6'b100000, 1'b0, 1'b1, 3, 4'b0010, 0, 0, 1, 1'b1}; // add ovf
    tbl[5]  = '{6'b000000, 6'b100010, 1'b0, 1'b0, 4, 4'b0110, 1, 0, 1, 1'b0}; // sub
    tbl[6]  = '{6'b000000, 6'b100100, 1'b0, 1'b1, 4, 4'b0000, 1, 0, 1, 1'b0}; // and
    tbl[7]  = '{6'b000000, 6'b100101, 1'b0, 1'b0, 4, 4'b0001, 1, 0, 1, 1'b0}; // or
    tbl[8]  = '{6'b001000, 6'b000000, 1'b0, 1'b0, 4, 4'b0010, 1, 0, 1, 1'b0}; // addi
    tbl[9]  = '{6'b001000, 6'b000000, 1'b0, 1'b1, 3, 4'b0010, 0, 0, 1, 1'b1}; // addi ovf
    tbl[10] = '{6'b001101, 6'b000000, 1'b0, 1'b1, 4, 4'b0001, 1, 0, 1, 1'b0}; // ori
    tbl[11] = '{6'b000100, 6'b000000, 1'b1, 1'b0, 3, 4'b0110, 0, 0, 2, 1'b0}; // beq taken
    tbl[12] = '{6'b000100, 6'b000000, 1'b0, 1'b0, 3, 4'b0110, 0, 0, 1, 1'b0}; // beq not taken
    tbl[13] = '{6'b000010, 6'b000000, 1'b0, 1'b0, 3, 4'b0010, 0, 0, 2, 1'b0}; // j
    tbl[14] = '{6'b111111, 6'b000000, 1'b0, 1'b0, 2, 4'b0010, 0, 0, 1, 1'b1}; // illegal op
    tbl[15] = '{6'b000000, 6'b000001, 1'b0, 1'b0, 2, 4'b0010, 0, 0, 1, 1'b1}; // bad funct
    ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000000, 6'b000100, 6'b001000, 6'b001101, 6'b000010};

    reset = 1'b1; opcode = 6'b0; funct = 6'b0; zero = 1'b0; overflow = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("reset_fetch", obs, V_F);
    reset = 1'b0;

    // Directed table: count enables over the instruction, then check where it lands.
    foreach (tbl[k]) begin
      logic [3:0] a3;
      int rw, mw, pe;
      rw = 0; mw = 0; pe = 0; a3 = 4'hx;
      opcode = tbl[k].op; funct = tbl[k].fn; zero = tbl[k].z; overflow = tbl[k].ov;
      #1;
      for (int c = 0; c < tbl[k].lat; c++) begin
        if (c == 2) a3 = aluOp;
        rw += int'(regWrite); mw += int'(memWrite); pe += int'(pcEn);
        @(negedge clk); #1;
      end
      if (tbl[k].lat == 2) a3 = aluOp;
      check($sformatf("tbl%0d aluop_cyc3", k), {13'h0, a3}, {13'h0, tbl[k].alu});
      check($sformatf("tbl%0d regwrite_cnt", k), 17'(rw), 17'(tbl[k].regw));
      check($sformatf("tbl%0d memwrite_cnt", k), 17'(mw), 17'(tbl[k].memw));
      check($sformatf("tbl%0d pcen_cnt", k), 17'(pe), 17'(tbl[k].pce));
      if (tbl[k].flt) begin
        check($sformatf("tbl%0d fault_entry", k), obs, V_FLT);
        fault_then_reset(10);
      end else begin
        check($sformatf("tbl%0d back_to_fetch", k), obs, V_F);
      end
    end

    // Reset during MEMRD of lw: no MEMWB write, FETCH follows.
    opcode = 6'b100011; funct = 6'b0; zero = 1'b0; overflow = 1'b0;
    #1;
    check("lwrst fetch", obs, V_F);
    @(negedge clk); #1; check("lwrst decode", obs, V_D);
    @(negedge clk); #1; check("lwrst memadr", obs, V_MA);
    @(negedge clk); #1; check("lwrst memrd", obs, V_MR);
    reset = 1'b1;
    @(negedge clk); #1;
    check("lwrst abandoned", obs, V_F);
    reset = 1'b0;
    run_model(6'b100011, 6'b0, 1'b0, 1'b0);

    // Randomized instructions against the model.
    for (int n = 0; n < 60; n++) begin
      logic [5:0] op, fn;
      logic [4:0] fsel;
      op = ($urandom_range(0, 9) < 8) ? ops[$urandom_range(0, 7)] : 6'($urandom_range(0, 63));
      fsel = 5'($urandom_range(0, 7));
      case (fsel)
        5'd0: fn = 6'b100000;
        5'd1: fn = 6'b100010;
        5'd2: fn = 6'b100100;
        5'd3: fn = 6'b100101;
        5'd4: fn = 6'b100111;
        5'd5: fn = 6'b101010;
        default: fn = 6'($urandom_range(0, 63));
      endcase
      run_model(op, fn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle main control FSM that issues operations to the CPU's ALU: it drives the 4-bit ALU op code, the ALU operand selects and all datapath enables.
- It consumes the ALU status flags `zero` and `overflow`.
- It sits between the instruction register and the datapath. It decodes a MIPS-subset opcode/funct and sequences fetch, decode, execute, memory and writeback, one state per clock.

Parameters:
- `OP_W`, 6, opcode and funct field width. Fixed ISA encoding; not intended to change.

Ports:
- `clk`, input, 1, system clock. All state updates on the rising edge.
- `reset`, input, 1, synchronous, active-high. Forces FETCH on the next edge.
- `opcode`, input, 6, IR[31:26]. Stable from the cycle after FETCH.
- `funct`, input, 6, IR[5:0].
- `zero`, input, 1, ALU result-is-zero flag.
- `overflow`, input, 1, ALU overflow flag. For op 0111 (SLT) it is the carry-out, not an overflow.
- `aluOp`, output, 4, ALU op: 0010 add, 0110 sub, 0111 slt, 0001 or, 0000 and, 1100 nor.
- `aluSrcA`, output, 1, 0 selects PC, 1 selects regA.
- `aluSrcB`, output, 2, 00 regB, 01 constant 4, 10 sign-extended immediate, 11 sign-extended immediate shifted left by 2.
- `pcEn`, output, 1, PC write enable.
- `pcSrc`, output, 2, 00 ALU result, 01 ALUOut register, 10 jump target.
- `iorD`, output, 1, memory address select: 0 PC, 1 ALUOut.
- `memWrite`, output, 1, data memory write.
- `irWrite`, output, 1, instruction register load.
- `regDst`, output, 1, 0 rt, 1 rd.
- `memToReg`, output, 1, 0 ALUOut, 1 memory data register.
- `regWrite`, output, 1, register file write.
- `fault`, output, 1, sticky: illegal instruction or arithmetic overflow.

Behaviour:
- Moore FSM with a 4-bit state register. Every output is a pure function of the state, except `pcEn` in BRANCH, which equals `zero`.
- Any output not listed for a state is 0. Unlisted ALU fields are don't-care, but drive `aluOp`=0010 and `aluSrcA`/`aluSrcB`=0.
- Reset: the state register loads FETCH. Outputs in the cycle after reset are the FETCH outputs. `fault`=0. Reset mid-instruction abandons it with no further writes.
- States and outputs:
  - FETCH: `iorD`=0, `irWrite`=1, `aluSrcA`=0, `aluSrcB`=01, `aluOp`=0010, `pcSrc`=00, `pcEn`=1. Next state DECODE.
  - DECODE: `aluSrcA`=0, `aluSrcB`=11, `aluOp`=0010 (branch target into ALUOut).
    - Next state by opcode: 100011/101011 to MEMADR, 000000 to RTEXEC, 000100 to BRANCH, 001000 to ADDIEX, 001101 to ORIEX, 000010 to JUMP.
    - Any other opcode goes to FAULT.
  - MEMADR: `aluSrcA`=1, `aluSrcB`=10, `aluOp`=0010. Next state MEMRD for lw, MEMWR for sw.
  - MEMRD: `iorD`=1. Next state MEMWB.
  - MEMWB: `regDst`=0, `memToReg`=1, `regWrite`=1. Next state FETCH.
  - MEMWR: `iorD`=1, `memWrite`=1. Next state FETCH.
  - RTEXEC: `aluSrcA`=1, `aluSrcB`=00, `aluOp` from funct: 100000 gives 0010, 100010 gives 0110, 100100 gives 0000, 100101 gives 0001, 100111 gives 1100, 101010 gives 0111.
    - The funct decode is registered in DECODE, so `aluOp` is Moore-stable in RTEXEC.
    - Unknown funct: DECODE transitions to FAULT instead.
    - Next state RTWB, or FAULT if `overflow`=1 and funct is add or sub. Overflow is ignored for slt/and/or/nor.
  - RTWB: `regDst`=1, `memToReg`=0, `regWrite`=1. Next state FETCH.
  - ADDIEX: `aluSrcA`=1, `aluSrcB`=10, `aluOp`=0010. Next state IMMWB, or FAULT if `overflow`=1.
  - ORIEX: `aluSrcA`=1, `aluSrcB`=10, `aluOp`=0001. Next state IMMWB. Overflow is ignored.
  - IMMWB: `regDst`=0, `memToReg`=0, `regWrite`=1. Next state FETCH.
  - BRANCH: `aluSrcA`=1, `aluSrcB`=00, `aluOp`=0110, `pcSrc`=01, `pcEn`=`zero`. Next state FETCH.
  - JUMP: `pcSrc`=10, `pcEn`=1. Next state FETCH.
  - FAULT: all enables 0, `fault`=1. Stays in FAULT until `reset`. `regWrite` and `pcEn` are never asserted for the faulting instruction.
- Latency in cycles, counted from FETCH entry back to FETCH: lw 5, sw 4, R-type 4, addi 4, ori 4, beq 3, j 3.
- Invariants: `memWrite` and `regWrite` are never both 1. `irWrite`=1 only in FETCH.

Test Plan:
- Reset asserted for 2 cycles, then released → FETCH outputs (`irWrite`=1, `pcEn`=1, `aluOp`=0010, `aluSrcB`=01). `fault`=0.
- lw (opcode 100011) → states FETCH, DECODE, MEMADR, MEMRD, MEMWB. `regWrite`=1 with `memToReg`=1 exactly in cycle 5, then FETCH.
- R-type nor (funct 100111) → `aluOp`=1100 in cycle 3, RTWB with `regDst`=1 in cycle 4. Repeat for slt with `overflow`=1 → `aluOp`=0111, writeback still occurs, `fault`=0.
- beq (000100) with `zero`=1 → `pcEn`=1, `pcSrc`=01 in cycle 3. With `zero`=0 → `pcEn`=0. Both return to FETCH.
- addi with `overflow`=1 in ADDIEX → no `regWrite`, FAULT entered, `fault`=1 held for 10 cycles until `reset`, then FETCH.
- Illegal opcode 111111, and R-type with funct 000001 → FAULT after DECODE. Assert `reset` during MEMRD of a lw → no MEMWB `regWrite`, FETCH next.
